// File: rtl/pool2_maxpool_pkg.sv
// Shared definitions for the conv2 -> pool2 path: FSM encoding, lane width and
// BRAM/pool address widths.
package pool2_maxpool_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int LANE_W      = 8;
  localparam int ADDR_W      = 11;
  localparam int POOL_ADDR_W = 9;

endpackage

// File: rtl/pool2_lane_max.sv
// One 8-bit lane of the 2x2 max pool: the first sample of a window loads the
// accumulator, later samples keep the signed maximum, the last one publishes it.
module pool2_lane_max
  import pool2_maxpool_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              first_i,
  input  logic              last_i,
  input  logic [LANE_W-1:0] sample_i,
  output logic [LANE_W-1:0] max_o
);

  logic [LANE_W-1:0] acc_q;
  logic [LANE_W-1:0] acc_d;
  logic [LANE_W-1:0] max_q;

  // Loading on the first sample means an all-negative window never reports zero.
  always_comb begin
    acc_d = acc_q;
    if (first_i || ($signed(sample_i) > $signed(acc_q))) begin
      acc_d = sample_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      max_q <= '0;
    end else if (valid_i) begin
      acc_q <= acc_d;
      if (last_i) begin
        max_q <= acc_d;
      end
    end
  end

  assign max_o = max_q;

endmodule

// File: rtl/pool2_maxpool.sv
// 2x2 stride-2 max pool over the conv2 result BRAM: streams four reads per window
// back to back and emits one pooled word per window.
module pool2_maxpool
  import pool2_maxpool_pkg::*;
#(
  parameter int COLS  = 36,
  parameter int ROWS  = 35,
  parameter int LANES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      enb2,
  output logic [ADDR_W-1:0]         addrb2,
  input  logic [LANES*LANE_W-1:0]   doutb2,
  output logic                      pool_valid,
  output logic [LANES*LANE_W-1:0]   pool_data,
  output logic [POOL_ADDR_W-1:0]    pool_addr,
  output logic                      busy,
  output logic                      done
);

  localparam int PR = ROWS / 2;
  localparam int PC = COLS / 2;
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] COLS2_A  = ADDR_W'(2 * COLS);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(PC - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(PR - 1);

  state_t                 state_q;
  logic [1:0]             phase_q;
  logic [ADDR_W-1:0]      colCnt_q;
  logic [ADDR_W-1:0]      rowCnt_q;
  logic [ADDR_W-1:0]      rowBase_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   enb2_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   rdValid_q;
  logic [1:0]             rdPhase_q;
  logic                   poolValid_q;
  logic [POOL_ADDR_W-1:0] poolAddr_q;
  logic [POOL_ADDR_W-1:0] winCnt_q;
  logic                   lastCol;
  logic                   lastRow;

  assign lastCol = (colCnt_q == LAST_COL);
  assign lastRow = (rowCnt_q == LAST_ROW);

  // Window read order is +0, +1, +COLS, +COLS+1; addresses advance by adds only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      colCnt_q  <= '0;
      rowCnt_q  <= '0;
      rowBase_q <= '0;
      addr_q    <= '0;
      enb2_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= READ;
            enb2_q    <= 1'b1;
            busy_q    <= 1'b1;
            phase_q   <= '0;
            colCnt_q  <= '0;
            rowCnt_q  <= '0;
            rowBase_q <= '0;
            addr_q    <= '0;
          end
        end
        READ: begin
          phase_q <= phase_q + 2'd1;
          case (phase_q)
            2'd0, 2'd2: addr_q <= addr_q + 11'd1;
            2'd1:       addr_q <= addr_q + COLS_A - 11'd1;
            default: begin
              if (lastCol) begin
                colCnt_q  <= '0;
                rowCnt_q  <= rowCnt_q + 11'd1;
                rowBase_q <= rowBase_q + COLS2_A;
                addr_q    <= rowBase_q + COLS2_A;
                if (lastRow) begin
                  state_q <= DRAIN;
                  enb2_q  <= 1'b0;
                  addr_q  <= '0;
                end
              end else begin
                colCnt_q <= colCnt_q + 11'd1;
                addr_q   <= addr_q - COLS_A + 11'd1;
              end
            end
          endcase
        end
        DRAIN: begin
          // The only strobe that can land while draining is the final window's.
          if (poolValid_q) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read data trails the address by one cycle, so the phase tag is delayed to match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdValid_q   <= 1'b0;
      rdPhase_q   <= '0;
      poolValid_q <= 1'b0;
      poolAddr_q  <= '0;
      winCnt_q    <= '0;
    end else begin
      rdValid_q   <= enb2_q;
      rdPhase_q   <= phase_q;
      poolValid_q <= rdValid_q && (rdPhase_q == 2'd3);
      if ((state_q == IDLE) && start) begin
        winCnt_q <= '0;
      end else if (rdValid_q && (rdPhase_q == 2'd3)) begin
        poolAddr_q <= winCnt_q;
        winCnt_q   <= winCnt_q + 9'd1;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : gLane
    pool2_lane_max uLane (
      .clk      (clk),
      .rst      (rst),
      .valid_i  (rdValid_q),
      .first_i  (rdPhase_q == 2'd0),
      .last_i   (rdPhase_q == 2'd3),
      .sample_i (doutb2[i*LANE_W +: LANE_W]),
      .max_o    (pool_data[i*LANE_W +: LANE_W])
    );
  end

  assign enb2       = enb2_q;
  assign addrb2     = addr_q;
  assign pool_valid = poolValid_q;
  assign pool_addr  = poolAddr_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_pool2_maxpool.sv
// Bench for pool2_maxpool: BRAM model, scoreboard of expected pooled words,
// address-trace tables and reset/restart corner cases.
module tb_pool2_maxpool;
  import pool2_maxpool_pkg::*;

  localparam int COLS   = 36;
  localparam int ROWS   = 35;
  localparam int LANES  = 16;
  localparam int DW     = LANES * 8;
  localparam int PR     = ROWS / 2;
  localparam int PC     = COLS / 2;
  localparam int NWIN   = PR * PC;
  localparam int NWORDS = COLS * ROWS;
  localparam int SCOLS  = 5;
  localparam int SROWS  = 3;

  typedef struct {
    logic [DW-1:0] data;
    logic [8:0]    addr;
  } exp_t;

  typedef struct {
    int          idx;
    logic [10:0] addr;
  } addrVec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          enb2;
  logic [10:0]   addrb2;
  logic [DW-1:0] doutb2;
  logic          pool_valid;
  logic [DW-1:0] pool_data;
  logic [8:0]    pool_addr;
  logic          busy;
  logic          done;

  logic          sStart;
  logic          sEnb2;
  logic [10:0]   sAddr;
  logic [DW-1:0] sDout;
  logic          sValid;
  logic [DW-1:0] sData;
  logic [8:0]    sPoolAddr;
  logic          sBusy;
  logic          sDone;

  logic [DW-1:0] mem  [NWORDS];
  logic [DW-1:0] memS [SCOLS*SROWS];

  exp_t        expQ[$];
  exp_t        sExpQ[$];
  exp_t        eMain;
  exp_t        eSmall;
  logic [10:0] readLog[$];
  logic [10:0] sReads[$];
  addrVec_t    addrTable[12];
  addrVec_t    smallTable[8];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int readCnt = 0;
  int strobeCnt = 0;
  int highRead = 0;
  int lastStrobeCycle = 0;
  int doneCycle = 0;
  int sStrobes = 0;
  bit logEn = 0;
  logic [DW-1:0] firstData;

  always #5 clk = ~clk;

  pool2_maxpool #(.COLS(COLS), .ROWS(ROWS), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .start(start), .enb2(enb2), .addrb2(addrb2),
    .doutb2(doutb2), .pool_valid(pool_valid), .pool_data(pool_data),
    .pool_addr(pool_addr), .busy(busy), .done(done)
  );

  pool2_maxpool #(.COLS(SCOLS), .ROWS(SROWS), .LANES(LANES)) dutSmall (
    .clk(clk), .rst(rst), .start(sStart), .enb2(sEnb2), .addrb2(sAddr),
    .doutb2(sDout), .pool_valid(sValid), .pool_data(sData),
    .pool_addr(sPoolAddr), .busy(sBusy), .done(sDone)
  );

  // One-cycle-latency BRAM models for both instances.
  always @(posedge clk) begin
    if (enb2) doutb2 <= mem[addrb2];
    if (sEnb2) sDout <= memS[sAddr];
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] maxOf4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c, input logic [DW-1:0] d);
    logic [DW-1:0]     r;
    logic signed [7:0] s [4];
    logic signed [7:0] m;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      s[0] = a[8*l +: 8];
      s[1] = b[8*l +: 8];
      s[2] = c[8*l +: 8];
      s[3] = d[8*l +: 8];
      m = s[0];
      for (int k = 1; k < 4; k++) if (s[k] > m) m = s[k];
      r[8*l +: 8] = m;
    end
    return r;
  endfunction

  task automatic pushFrame();
    exp_t e;
    int   b;
    for (int pr = 0; pr < PR; pr++) begin
      for (int pc = 0; pc < PC; pc++) begin
        b = 2*pr*COLS + 2*pc;
        e.data = maxOf4(mem[b], mem[b+1], mem[b+COLS], mem[b+COLS+1]);
        e.addr = 9'(pr*PC + pc);
        expQ.push_back(e);
      end
    end
  endtask

  task automatic fillRandom();
    for (int w = 0; w < NWORDS; w++) mem[w] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic clearCounters();
    readCnt = 0;
    strobeCnt = 0;
    highRead = 0;
    lastStrobeCycle = 0;
    doneCycle = 0;
  endtask

  task automatic applyStimulus();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("first read enb2", enb2, 1);
    checkOutput("first read addr", addrb2, 0);
    checkOutput("busy on first read", busy, 1);
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (n < budget && done !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) checkOutput("done timeout", 0, 1);
    else checkOutput("busy at done", busy, 1);
  endtask

  task automatic checkFrameEnd(input string tag);
    @(negedge clk);
    checkOutput({tag, " busy after done"}, busy, 0);
    checkOutput({tag, " strobe count"}, strobeCnt, NWIN);
    checkOutput({tag, " read cycles"}, readCnt, 4*NWIN);
    checkOutput({tag, " done latency"}, doneCycle - lastStrobeCycle, 1);
    checkOutput({tag, " leftover expected"}, expQ.size(), 0);
    checkOutput({tag, " unused addr read"}, highRead, 0);
  endtask

  always @(negedge clk) begin
    cycle++;
    if (enb2) begin
      readCnt++;
      if (addrb2 >= 11'(2*PR*COLS)) highRead++;
      if (logEn) readLog.push_back(addrb2);
    end
    if (pool_valid) begin
      if (strobeCnt == 0) firstData = pool_data;
      strobeCnt++;
      lastStrobeCycle = cycle;
      if (expQ.size() == 0) begin
        checkOutput("unexpected strobe", 1, 0);
      end else begin
        eMain = expQ.pop_front();
        checkOutput("pool_data", pool_data, eMain.data);
        checkOutput("pool_addr", pool_addr, eMain.addr);
      end
    end
    if (done) doneCycle = cycle;
    if (sEnb2) sReads.push_back(sAddr);
    if (sValid) begin
      sStrobes++;
      if (sExpQ.size() == 0) begin
        checkOutput("small unexpected strobe", 1, 0);
      end else begin
        eSmall = sExpQ.pop_front();
        checkOutput("small pool_data", sData, eSmall.data);
        checkOutput("small pool_addr", sPoolAddr, eSmall.addr);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    logic [7:0] neg [4];

    addrTable[0]  = '{0, 11'd0};    addrTable[1]  = '{1, 11'd1};
    addrTable[2]  = '{2, 11'd36};   addrTable[3]  = '{3, 11'd37};
    addrTable[4]  = '{4, 11'd2};    addrTable[5]  = '{5, 11'd3};
    addrTable[6]  = '{6, 11'd38};   addrTable[7]  = '{7, 11'd39};
    addrTable[8]  = '{72, 11'd72};  addrTable[9]  = '{73, 11'd73};
    addrTable[10] = '{74, 11'd108}; addrTable[11] = '{75, 11'd109};
    smallTable[0] = '{0, 11'd0}; smallTable[1] = '{1, 11'd1};
    smallTable[2] = '{2, 11'd5}; smallTable[3] = '{3, 11'd6};
    smallTable[4] = '{4, 11'd2}; smallTable[5] = '{5, 11'd3};
    smallTable[6] = '{6, 11'd7}; smallTable[7] = '{7, 11'd8};

    rst = 1'b1;
    start = 1'b0;
    sStart = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset enb2", enb2, 0);
    checkOutput("reset addrb2", addrb2, 0);
    checkOutput("reset pool_valid", pool_valid, 0);
    checkOutput("reset pool_data", pool_data, 0);
    checkOutput("reset pool_addr", pool_addr, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Frame A: ramp map, lane 3 of window 0 all negative, address trace logged.
    for (int w = 0; w < NWORDS; w++) mem[w] = {LANES{8'(w % 128)}};
    neg[0] = 8'hFB; neg[1] = 8'h80; neg[2] = 8'hFF; neg[3] = 8'hEC;
    mem[0][31:24] = neg[0];
    mem[1][31:24] = neg[1];
    mem[COLS][31:24] = neg[2];
    mem[COLS+1][31:24] = neg[3];
    clearCounters();
    pushFrame();
    logEn = 1;
    applyStimulus();
    waitDone(3000);
    logEn = 0;
    checkFrameEnd("ramp");
    checkOutput("window0 lane0", firstData[7:0], 8'd37);
    checkOutput("window0 lane3 negative", firstData[31:24], 8'hFF);
    for (int i = 0; i < 12; i++) begin
      if (addrTable[i].idx < readLog.size())
        checkOutput($sformatf("addr trace %0d", addrTable[i].idx), readLog[addrTable[i].idx], addrTable[i].addr);
      else
        checkOutput("addr trace too short", readLog.size(), addrTable[i].idx + 1);
    end

    // Frame B: random map, extra start mid-read and a start during FIN.
    fillRandom();
    clearCounters();
    pushFrame();
    applyStimulus();
    repeat (99) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(3000);
    start = 1'b1;
    checkFrameEnd("restart-ignore");
    start = 1'b0;
    @(negedge clk);
    checkOutput("start in FIN ignored enb2", enb2, 0);
    checkOutput("start in FIN ignored busy", busy, 0);

    // Frame C: reset mid-frame, then a fresh full frame.
    fillRandom();
    clearCounters();
    pushFrame();
    applyStimulus();
    repeat (500) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midreset enb2", enb2, 0);
    checkOutput("midreset addrb2", addrb2, 0);
    checkOutput("midreset pool_valid", pool_valid, 0);
    checkOutput("midreset pool_data", pool_data, 0);
    checkOutput("midreset pool_addr", pool_addr, 0);
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset done", done, 0);
    expQ.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("no resume enb2", enb2, 0);
    checkOutput("no resume busy", busy, 0);
    fillRandom();
    clearCounters();
    pushFrame();
    applyStimulus();
    waitDone(3000);
    checkFrameEnd("after-reset");

    // Small map: 5 columns x 3 rows gives two windows.
    for (int w = 0; w < SCOLS*SROWS; w++) memS[w] = {$urandom, $urandom, $urandom, $urandom};
    sReads.delete();
    sStrobes = 0;
    for (int pc = 0; pc < 2; pc++) begin
      e.data = maxOf4(memS[2*pc], memS[2*pc+1], memS[2*pc+SCOLS], memS[2*pc+SCOLS+1]);
      e.addr = 9'(pc);
      sExpQ.push_back(e);
    end
    @(negedge clk);
    sStart = 1'b1;
    @(negedge clk);
    sStart = 1'b0;
    for (int n = 0; n < 50 && sDone !== 1'b1; n++) @(negedge clk);
    checkOutput("small done", sDone, 1);
    @(negedge clk);
    checkOutput("small strobes", sStrobes, 2);
    checkOutput("small read count", sReads.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < sReads.size())
        checkOutput($sformatf("small addr %0d", i), sReads[i], smallTable[i].addr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pool2_maxpool.md
POOL2_MAXPOOL -- requirements
Module: pool2_maxpool

Interface
REQ-001 Parameter COLS, default 36, feature-map width in words.
REQ-002 Parameter ROWS, default 35, feature-map height in words; COLS*ROWS SHALL be at most 2048.
REQ-003 Parameter LANES, default 16, number of 8-bit channels per word.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse marking conv2 buffer full; sampled only in IDLE.
REQ-007 enb2  out  1  read enable for the conv2 result BRAM (port B).
REQ-008 addrb2  out  11  BRAM read address (row-major, word = r*COLS + c).
REQ-009 doutb2  in  128  BRAM read data; valid exactly 1 cycle after enb2/addrb2; lane i at bits [8i+7:8i].
REQ-010 pool_valid  out  1  one-cycle strobe, pooled word present.
REQ-011 pool_data  out  128  pooled word, lane-aligned with doutb2.
REQ-012 pool_addr  out  9  index of pooled word, 0..(ROWS/2)*(COLS/2)-1, row-major.
REQ-013 busy  out  1  high from the first read cycle through the done cycle.
REQ-014 done  out  1  one-cycle pulse after the final pool_valid.

Function
REQ-015 FSM states: IDLE, READ, DRAIN, FIN; IDLE->READ on start, READ->DRAIN after the last read issued, DRAIN->FIN when the last pool_valid fires, FIN->IDLE unconditionally.
REQ-016 Output window count: PR=floor(ROWS/2) by PC=floor(COLS/2); an odd trailing row or column is never read (defaults: 17x18 = 306 windows).
REQ-017 Per window (pr,pc), read order: (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1).
REQ-018 In READ, enb2 is high every cycle with no gaps, including across window and row boundaries; total read cycles = 4*PR*PC.
REQ-019 First read (addrb2=0) is issued in the cycle after start is sampled.
REQ-020 Addresses come from incremental row-base/column counters; no multiplier.
REQ-021 Per lane: signed 8-bit two's-complement maximum of the four samples; the first sample loads the accumulator, it is not compared against zero.
REQ-022 pool_valid asserts 2 cycles after the 4th read address of a window (1 BRAM latency + 1 output register); pool_data and pool_addr are registered and held until the next strobe.
REQ-023 pool_addr starts at 0 and increments by 1 per strobe.
REQ-024 done pulses in the FIN cycle, 1 cycle after the final pool_valid; busy drops in the following cycle.
REQ-025 start while not IDLE is ignored; start in the same cycle as FIN is ignored.
REQ-026 enb2 is low outside READ, and addrb2 is then held at 0.

Reset
REQ-027 Asserting rst at any time, including mid-frame, forces IDLE, clears all counters and accumulators, and drives enb2, addrb2, pool_valid, pool_data, pool_addr, busy and done to 0 asynchronously.
REQ-028 After rst deasserts, the block waits for a fresh start pulse; a partial frame is never resumed.

Structure
REQ-029 Shared package holds the FSM state encoding, LANE_W=8, and the BRAM address width (11) used by conv2 write/read stages.
REQ-030 One sub-module, pool2_lane_max, implements one lane's load/compare/hold and is instantiated LANES times.

Verification
REQ-031 Ramp map (word w, all lanes = w mod 128), default params, start -> 306 strobes; pool_data[7:0] for window 0 = 37; done 1 cycle after strobe 305; total 1224 read cycles.
REQ-032 Window 0 lane 3 samples {-5,-128,-1,-20} -> lane 3 output = -1 (0xFF); all-negative input never yields 0.
REQ-033 Address trace: first 8 addrb2 = 0,1,36,37,2,3,38,39; window 18 begins at 72,73,108,109; addresses 1224..1259 never read.
REQ-034 start pulsed again at read cycle 100 -> ignored; strobe count stays 306, pool_addr sequence stays unbroken.
REQ-035 rst asserted at read cycle 500 -> all outputs 0 immediately; new start -> pool_addr restarts at 0, 306 strobes.
REQ-036 COLS=5, ROWS=3 -> 2 windows, reads 0,1,5,6,2,3,7,8; column 4 and row 2 unused.
